// File: rtl/net_sweep_ctrl_if.sv
// Controller <-> net-core bus: reset, start pulse, float inputs/outputs and done level.
interface net_sweep_ctrl_if #(
    parameter int unsigned I = 2,
    parameter int unsigned O = 1
);
    logic              net_rst_n;
    logic              net_start;
    logic [32*I-1:0]   net_x;
    logic [32*O-1:0]   net_y;
    logic              net_done;

    modport master (
        output net_rst_n,
        output net_start,
        output net_x,
        input  net_y,
        input  net_done
    );

    modport slave (
        input  net_rst_n,
        input  net_start,
        input  net_x,
        output net_y,
        output net_done
    );
endinterface

// File: rtl/net_sweep_ctrl.sv
// Drives a binary-classifier net core over one pattern or all 2^I patterns and grades
// output lane 0 against the XOR parity of each pattern.
module net_sweep_ctrl #(
    parameter int unsigned I   = 2,
    parameter int unsigned O   = 1,
    parameter int unsigned TMO = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             mode,
    input  logic [I-1:0]     sw,
    net_sweep_ctrl_if.master net,
    output logic [O-1:0]     result,
    output logic             expected,
    output logic             busy,
    output logic             fin,
    output logic [I:0]       err_cnt,
    output logic             timeout,
    output logic             pass
);

    localparam int unsigned TW      = $clog2(TMO + 1);
    localparam logic [TW-1:0] TmoLast = TW'(TMO - 1);
    localparam logic [TW-1:0] TimOne  = TW'(1);
    localparam logic [I:0]    ErrOne  = {{I{1'b0}}, 1'b1};
    localparam logic [I-1:0]  PatOne  = {{(I-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {StIdle, StRst, StLoad, StWait, StCheck, StNext, StFin} state_e;

    state_e state_q, state_d;

    logic            mode_q;
    logic [I-1:0]    pat_q;
    logic            net_rst_n_q, net_start_q;
    logic [32*I-1:0] net_x_q, net_x_d;
    logic [TW-1:0]   timer_q;
    logic            tmo_pat_q;
    logic [O-1:0]    result_q, res_now;
    logic            expected_q;
    logic [I:0]      err_q;
    logic            timeout_q, pass_q;

    logic go_acc, pat_inc, tmo_hit, timer_last, check_en, fin_en, lane0_nan, err_now;

    function automatic logic is_nan(input logic [31:0] y);
        return (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    endfunction

    // Strictly above 0.5: 0.5 itself, any negative (incl. -0) and NaN grade as 0.
    function automatic logic thresh(input logic [31:0] y);
        return !y[31] && !is_nan(y) && (y[30:0] > 31'h3F00_0000);
    endfunction

    // The timer reaches TMO-1 on the edge that leaves WAIT; net_done in that cycle wins.
    assign timer_last = ((timer_q + TimOne) == TmoLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (go) state_d = StRst;
            StRst:   state_d = StLoad;
            StLoad:  state_d = StWait;
            StWait:  if (net.net_done || timer_last) state_d = StCheck;
            StCheck: state_d = StNext;
            StNext:  state_d = (!mode_q || (pat_q == '1)) ? StFin : StRst;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = (state_q != StIdle);
        fin      = (state_q == StFin);
        go_acc   = (state_q == StIdle) && go;
        pat_inc  = (state_q == StNext) && (state_d == StRst);
        tmo_hit  = (state_q == StWait) && !net.net_done && timer_last;
        check_en = (state_q == StCheck);
        fin_en   = (state_q == StFin);
    end

    always_comb begin
        net_x_d = '0;
        for (int k = 0; k < I; k++) begin
            if (pat_q[k]) net_x_d[32*k +: 32] = 32'h3F80_0000;
        end
        res_now = '0;
        for (int k = 0; k < O; k++) begin
            res_now[k] = thresh(net.net_y[32*k +: 32]);
        end
        lane0_nan = is_nan(net.net_y[31:0]);
        // At most one increment per pattern, whichever faults coincide.
        err_now   = (res_now[0] != (^pat_q)) || tmo_pat_q || lane0_nan;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= 1'b0;
            pat_q       <= '0;
            net_rst_n_q <= 1'b0;
            net_start_q <= 1'b0;
            net_x_q     <= '0;
            timer_q     <= '0;
            tmo_pat_q   <= 1'b0;
            result_q    <= '0;
            expected_q  <= 1'b0;
            err_q       <= '0;
            timeout_q   <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            net_rst_n_q <= (state_d != StRst);
            net_start_q <= (state_d == StLoad);
            if (state_d == StLoad) net_x_q <= net_x_d;
            timer_q <= (state_q == StWait) ? timer_q + TimOne : '0;
            if (go_acc) begin
                mode_q    <= mode;
                pat_q     <= mode ? '0 : sw;
                err_q     <= '0;
                timeout_q <= 1'b0;
                pass_q    <= 1'b0;
            end
            if (pat_inc) pat_q <= pat_q + PatOne;
            if (state_q == StLoad) tmo_pat_q <= 1'b0;
            if (tmo_hit) begin
                tmo_pat_q <= 1'b1;
                timeout_q <= 1'b1;
            end
            if (check_en) begin
                result_q   <= res_now;
                expected_q <= ^pat_q;
                if (err_now && (err_q != '1)) err_q <= err_q + ErrOne;
            end
            if (fin_en) pass_q <= (err_q == '0) && !timeout_q;
        end
    end

    assign net.net_rst_n = net_rst_n_q;
    assign net.net_start = net_start_q;
    assign net.net_x     = net_x_q;
    assign result        = result_q;
    assign expected      = expected_q;
    assign err_cnt       = err_q;
    assign timeout       = timeout_q;
    assign pass          = pass_q;

endmodule

// File: tb/tb_net_sweep_ctrl.sv
// Directed bench: three controller instances (I=2, I=2 with TMO=16, I=3) each with a
// small behavioural net-core model; table-driven single runs plus hand-written sequences.
module tb_net_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] go_v;
    logic       mode;
    logic [2:0] sw;
    int n_vec = 0;
    int n_bad = 0;

    net_sweep_ctrl_if #(.I(2), .O(1)) a_if();
    net_sweep_ctrl_if #(.I(2), .O(1)) t_if();
    net_sweep_ctrl_if #(.I(3), .O(1)) c_if();

    logic       a_result, a_exp, a_busy, a_fin, a_tmo, a_pass;
    logic [2:0] a_err;
    logic       t_result, t_exp, t_busy, t_fin, t_tmo, t_pass;
    logic [2:0] t_err;
    logic       c_result, c_exp, c_busy, c_fin, c_tmo, c_pass;
    logic [3:0] c_err;
    logic [2:0] fin_v, pass_v;
    assign fin_v  = {c_fin, t_fin, a_fin};
    assign pass_v = {c_pass, t_pass, a_pass};

    net_sweep_ctrl #(.I(2), .O(1), .TMO(1024)) dut_a (
        .clk(clk), .rst_n(rst_n), .go(go_v[0]), .mode(mode), .sw(sw[1:0]), .net(a_if),
        .result(a_result), .expected(a_exp), .busy(a_busy), .fin(a_fin),
        .err_cnt(a_err), .timeout(a_tmo), .pass(a_pass)
    );
    net_sweep_ctrl #(.I(2), .O(1), .TMO(16)) dut_t (
        .clk(clk), .rst_n(rst_n), .go(go_v[1]), .mode(mode), .sw(sw[1:0]), .net(t_if),
        .result(t_result), .expected(t_exp), .busy(t_busy), .fin(t_fin),
        .err_cnt(t_err), .timeout(t_tmo), .pass(t_pass)
    );
    net_sweep_ctrl #(.I(3), .O(1), .TMO(1024)) dut_c (
        .clk(clk), .rst_n(rst_n), .go(go_v[2]), .mode(mode), .sw(sw), .net(c_if),
        .result(c_result), .expected(c_exp), .busy(c_busy), .fin(c_fin),
        .err_cnt(c_err), .timeout(c_tmo), .pass(c_pass)
    );

    function automatic logic [31:0] ideal(input logic par);
        return par ? 32'h3F80_0000 : 32'h0000_0000;
    endfunction

    // Net-core models: done rises on the dly-th cycle after the start pulse was sampled.
    logic [1:0]  a_pat;
    logic [2:0]  c_pat;
    int          a_delay, a_ymode;
    logic [31:0] a_cval;
    logic        a_done, a_armed, c_done, c_armed;
    int          a_cnt, c_cnt;
    int          a_rst_cnt = 0, a_fin_cnt = 0, t_starts = 0, c_starts = 0;
    int          a_q[$];

    always_comb begin
        for (int k = 0; k < 2; k++) a_pat[k] = (a_if.net_x[32*k +: 32] == 32'h3F80_0000);
        for (int k = 0; k < 3; k++) c_pat[k] = (c_if.net_x[32*k +: 32] == 32'h3F80_0000);
    end

    assign a_if.net_y    = (a_ymode == 0) ? ideal(^a_pat) : a_cval;
    assign a_if.net_done = a_done;
    assign t_if.net_y    = 32'h0;
    assign t_if.net_done = 1'b0;
    assign c_if.net_y    = (c_pat == 3'd5) ? 32'h7FC0_0000 : ideal(^c_pat);
    assign c_if.net_done = c_done;

    always @(posedge clk) begin
        if (!a_if.net_rst_n) begin
            a_done <= 1'b0; a_armed <= 1'b0; a_cnt <= 0;
        end else if (a_if.net_start) begin
            a_armed <= 1'b1; a_cnt <= 1; a_done <= (a_delay == 1);
        end else if (a_armed) begin
            a_cnt <= a_cnt + 1;
            if (a_cnt + 1 >= a_delay) a_done <= 1'b1;
        end
        if (!c_if.net_rst_n) begin
            c_done <= 1'b0; c_armed <= 1'b0; c_cnt <= 0;
        end else if (c_if.net_start) begin
            c_armed <= 1'b1; c_cnt <= 1; c_done <= 1'b0;
        end else if (c_armed) begin
            c_cnt <= c_cnt + 1;
            if (c_cnt + 1 >= 2) c_done <= 1'b1;
        end
        if (rst_n) begin
            if (!a_if.net_rst_n) a_rst_cnt <= a_rst_cnt + 1;
            if (a_if.net_start) a_q.push_back(int'(a_pat));
            if (a_fin) a_fin_cnt <= a_fin_cnt + 1;
            if (t_if.net_start && t_if.net_x == 64'd0) t_starts <= t_starts + 1;
            if (c_if.net_start) c_starts <= c_starts + 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
        end
    endtask

    // Pulse go on instance 'which'; lat = cycle index (go cycle = 0) in which fin is seen.
    task automatic run(input int which, input logic m, input logic [2:0] s, input bit disturb,
                       output int lat, output logic p1);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        p1   = 1'b0;
        @(negedge clk);
        mode = m; sw = s; go_v = '0; go_v[which] = 1'b1;
        for (int c = 1; c <= 3000 && !seen; c++) begin
            @(posedge clk);
            @(negedge clk);
            go_v = '0;
            if (disturb) begin
                go_v[which] = (c % 2 == 1);
                mode = ~m; sw = ~s;
            end
            if (c == 1) p1 = pass_v[which];
            if (fin_v[which]) begin
                seen = 1'b1; lat = c;
            end
        end
        go_v = '0; mode = m; sw = s;
        chk("fin_seen", {63'd0, seen}, 64'd1);
    endtask

    typedef struct {
        logic [1:0]  sw;
        logic [31:0] y;
        int          dly;
        logic        res;
        logic        expb;
        int          err;
        logic        pass;
    } vec_t;

    vec_t vt[11];
    int   lat, f0, r0;
    logic p1;
    bit   seen;

    initial begin
        vt[0]  = '{2'b01, 32'h3F40_0000, 3, 1'b1, 1'b1, 0, 1'b1};
        vt[1]  = '{2'b01, 32'h3F00_0000, 1, 1'b0, 1'b1, 1, 1'b0};
        vt[2]  = '{2'b11, 32'h3F00_0001, 2, 1'b1, 1'b0, 1, 1'b0};
        vt[3]  = '{2'b00, 32'hBF80_0000, 1, 1'b0, 1'b0, 0, 1'b1};
        vt[4]  = '{2'b10, 32'h8000_0000, 2, 1'b0, 1'b1, 1, 1'b0};
        vt[5]  = '{2'b10, 32'h7FC0_0000, 1, 1'b0, 1'b1, 1, 1'b0};
        vt[6]  = '{2'b00, 32'h7FC0_0000, 2, 1'b0, 1'b0, 1, 1'b0};
        vt[7]  = '{2'b01, 32'h7F80_0000, 1, 1'b1, 1'b1, 0, 1'b1};
        vt[8]  = '{2'b11, 32'h0000_0000, 4, 1'b0, 1'b0, 0, 1'b1};
        vt[9]  = '{2'b10, 32'h3F00_0001, 5, 1'b1, 1'b1, 0, 1'b1};
        vt[10] = '{2'b01, 32'h7F80_0001, 1, 1'b0, 1'b1, 1, 1'b0};

        rst_n = 1'b0; go_v = '0; mode = 1'b0; sw = '0;
        a_delay = 3; a_ymode = 0; a_cval = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_net_rst_n", {63'd0, a_if.net_rst_n}, 64'd0);
        chk("rst_busy", {63'd0, a_busy}, 64'd0);
        chk("rst_err", {61'd0, a_err}, 64'd0);
        chk("rst_pass", {63'd0, a_pass}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_net_rst_n", {63'd0, a_if.net_rst_n}, 64'd1);
        repeat (3) @(negedge clk);
        chk("rel_no_run", {63'd0, a_busy}, 64'd0);

        // Single-mode runs on dut_a with a constant model output.
        for (int i = 0; i < 11; i++) begin
            a_ymode = 1; a_cval = vt[i].y; a_delay = vt[i].dly;
            run(0, 1'b0, {1'b0, vt[i].sw}, 1'b0, lat, p1);
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vt[i].dly + 5));
            chk($sformatf("v%0d_result", i), {63'd0, a_result}, {63'd0, vt[i].res});
            chk($sformatf("v%0d_expect", i), {63'd0, a_exp}, {63'd0, vt[i].expb});
            chk($sformatf("v%0d_err", i), {61'd0, a_err}, 64'(vt[i].err));
            chk($sformatf("v%0d_timeout", i), {63'd0, a_tmo}, 64'd0);
            chk($sformatf("v%0d_pass_clr", i), {63'd0, p1}, 64'd0);
            @(negedge clk);
            chk($sformatf("v%0d_pass", i), {63'd0, a_pass}, {63'd0, vt[i].pass});
            chk($sformatf("v%0d_fin_pulse", i), {62'd0, a_fin, a_busy}, 64'd0);
        end

        // Ideal XOR model sweep.
        a_ymode = 0; a_delay = 2; a_q.delete(); f0 = a_fin_cnt; r0 = a_rst_cnt;
        run(0, 1'b1, 3'b000, 1'b0, lat, p1);
        repeat (3) @(negedge clk);
        chk("sw_starts", 64'(a_q.size()), 64'd4);
        for (int k = 0; k < 4 && k < a_q.size(); k++)
            chk($sformatf("sw_pat%0d", k), 64'(a_q[k]), 64'(k));
        chk("sw_rst_cycles", 64'(a_rst_cnt - r0), 64'd4);
        chk("sw_fin_count", 64'(a_fin_cnt - f0), 64'd1);
        chk("sw_err", {61'd0, a_err}, 64'd0);
        chk("sw_pass", {63'd0, a_pass}, 64'd1);

        // Sweep with output stuck at exactly 0.5.
        a_ymode = 1; a_cval = 32'h3F00_0000;
        run(0, 1'b1, 3'b000, 1'b0, lat, p1);
        @(negedge clk);
        chk("half_result", {63'd0, a_result}, 64'd0);
        chk("half_err", {61'd0, a_err}, 64'd2);
        chk("half_pass", {63'd0, a_pass}, 64'd0);

        // Timeout: net_done never arrives, TMO=16.
        run(1, 1'b0, 3'b001, 1'b0, lat, p1);
        chk("tmo_lat", 64'(lat), 64'd20);
        chk("tmo_flag", {63'd0, t_tmo}, 64'd1);
        chk("tmo_err", {61'd0, t_err}, 64'd1);
        @(negedge clk);
        chk("tmo_pass", {63'd0, t_pass}, 64'd0);

        // I=3 sweep with NaN on pattern 5 only.
        run(2, 1'b1, 3'b000, 1'b0, lat, p1);
        @(negedge clk);
        chk("nan_starts", 64'(c_starts), 64'd8);
        chk("nan_err", {60'd0, c_err}, 64'd1);
        chk("nan_timeout", {63'd0, c_tmo}, 64'd0);
        chk("nan_pass", {63'd0, c_pass}, 64'd0);

        // Reset in the middle of a sweep, then a disturbed single run.
        a_ymode = 0; a_delay = 3;
        @(negedge clk); mode = 1'b1; go_v = 3'b001;
        @(negedge clk); go_v = '0;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (a_if.net_start && a_pat == 2'd2) seen = 1'b1;
        end
        chk("mid_reach_p2", {63'd0, seen}, 64'd1);
        chk("mid_res_pre", {63'd0, a_result}, 64'd1);
        rst_n = 1'b0; #1;
        chk("mid_rst_net", {62'd0, a_if.net_rst_n, a_if.net_start}, 64'd0);
        chk("mid_rst_x", a_if.net_x, 64'd0);
        chk("mid_rst_out", {58'd0, a_result, a_exp, a_busy, a_fin, a_tmo, a_pass}, 64'd0);
        chk("mid_rst_err", {61'd0, a_err}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rel_net_rst_n", {63'd0, a_if.net_rst_n}, 64'd1);
        repeat (4) @(negedge clk);
        chk("mid_idle", {63'd0, a_busy}, 64'd0);
        a_q.delete(); f0 = a_fin_cnt;
        run(0, 1'b0, 3'b011, 1'b1, lat, p1);
        chk("mid_lat", 64'(lat), 64'd8);
        repeat (6) @(negedge clk);
        chk("mid_starts", 64'(a_q.size()), 64'd1);
        chk("mid_fin_count", 64'(a_fin_cnt - f0), 64'd1);
        chk("mid_busy", {63'd0, a_busy}, 64'd0);
        chk("mid_result", {62'd0, a_result, a_exp}, 64'd0);
        chk("mid_err", {61'd0, a_err}, 64'd0);
        chk("mid_pass", {63'd0, a_pass}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/net_sweep_ctrl.md
NET_SWEEP_CTRL -- requirements
Module: net_sweep_ctrl

Interface
REQ-001 Parameter I, default 2, number of binary classifier inputs (1..8).
REQ-002 Parameter O, default 1, number of net outputs; only output 0 is graded.
REQ-003 Parameter TMO, default 1024, maximum cycles to wait for net_done per pattern.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 go  in  1  single-cycle conditioned start pulse.
REQ-007 mode  in  1  0 = single run on sw; 1 = sweep all 2^I patterns.
REQ-008 sw  in  I  user input bits for single mode.
REQ-009 net_rst_n  out  1  active-low reset to net core.
REQ-010 net_start  out  1  start pulse to net core.
REQ-011 net_x  out  32*I  IEEE-754 single inputs; lane k = 1.0 (0x3F800000) if pattern bit k is 1, else 0x00000000.
REQ-012 net_y  in  32*O  IEEE-754 single outputs of net core.
REQ-013 net_done  in  1  net core completion level.
REQ-014 result  out  O  thresholded outputs of the most recent pattern.
REQ-015 expect  out  1  XOR-parity of the most recent pattern.
REQ-016 busy  out  1  high from the cycle after go is accepted until FIN exits.
REQ-017 fin  out  1  one-cycle pulse when a run (single or sweep) completes.
REQ-018 err_cnt  out  I+1  count of graded mismatches in the current run.
REQ-019 timeout  out  1  sticky: set if any pattern in the current run timed out.
REQ-020 pass  out  1  high after fin when err_cnt = 0 and timeout = 0; cleared on next accepted go.

Function
REQ-021 FSM states: IDLE, RST, LOAD, WAIT, CHECK, NEXT, FIN.
REQ-022 IDLE: go=1 -> RST; latch mode; pattern = sw (mode 0) or 0 (mode 1); clear err_cnt, timeout, pass.
REQ-023 go while busy is ignored; mode and sw changes while busy are ignored.
REQ-024 RST: net_rst_n = 0 for exactly one cycle -> LOAD.
REQ-025 LOAD: net_x registered from pattern; net_start = 1 for exactly one cycle; net_rst_n = 1 -> WAIT.
REQ-026 net_x holds stable from LOAD until the next LOAD.
REQ-027 WAIT: timer counts from 0 each entry; net_done = 1 -> CHECK; timer reaches TMO-1 without net_done -> set timeout, CHECK.
REQ-028 Threshold per lane: bit = 1 iff sign = 0, not NaN, and y[30:0] > 0x3F000000; exactly 0.5, negatives, -0 and NaN give 0.
REQ-029 CHECK: register result and expect; err_cnt += 1 if result[0] != expect, or if the pattern timed out, or if lane 0 is NaN (one increment maximum per pattern) -> NEXT.
REQ-030 err_cnt saturates at all-ones; no wrap.
REQ-031 NEXT: mode 0 -> FIN; mode 1 and pattern = 2^I-1 -> FIN; otherwise pattern += 1 -> RST.
REQ-032 FIN: fin = 1, pass evaluated, busy drops -> IDLE next cycle.
REQ-033 net_done asserted outside WAIT is ignored.
REQ-034 Latency, single mode, net_done on Nth WAIT cycle: go to fin = N + 5 cycles.

Reset
REQ-035 rst_n low, at any time including mid-sweep: state IDLE immediately; net_rst_n = 0, net_start = 0, net_x = 0, result = 0, expect = 0, busy = 0, fin = 0, err_cnt = 0, timeout = 0, pass = 0.
REQ-036 After rst_n release net_rst_n returns to 1 on the first clock edge; no run starts without a new go.

Verification
REQ-037 I=2, mode 0, sw=2'b01, model returns 0x3F400000 after 3 cycles -> result=1, expect=1, err_cnt=0, pass=1, fin 8 cycles after go.
REQ-038 I=2, mode 1, ideal XOR model -> 4 RST/LOAD cycles, patterns 0..3 in order, err_cnt=0, pass=1, single fin pulse.
REQ-039 I=2, mode 1, model always returns 0x3F000000 -> result=0 every pattern, err_cnt=2, pass=0.
REQ-040 TMO=16, net_done never asserted, mode 0 -> fin 16+4 cycles after go, timeout=1, err_cnt=1, pass=0.
REQ-041 Mid-sweep rst_n pulse at pattern 2, then go with mode 0 -> all outputs at reset values, new run completes normally, go pulses during busy produce no extra runs.
REQ-042 I=3, model returns NaN 0x7FC00000 for pattern 5 only, else ideal parity -> err_cnt=1, pass=0.
